dsp_chain_sop_sequencer: RTL and testbench
==========================================

# dsp_chain_sop_sequencer

Job sequencer for a 4-stage fp16 sum-of-two-products DSP cascade. It accepts a dot-product job of `len` beats. Each beat carries the 16 fp16 operands for all four DSPs. The block streams those beats into the cascade and tags each one through the cascade's fixed pipeline latency. It captures the cascaded fp32 results into an output FIFO under credit-based flow control, because the cascade cannot stall, and reports job completion. It sits between the operand-fetch logic and the cascade, and owns all handshaking around it.

## Interface
- `LAT`, 4: cycles from `dsp_ops` update to the matching `dsp_result`.
- `DEPTH`, 8: output FIFO entries; also the total credit limit; power of two, ≥ 2.
- `LEN_W`, 16: width of the job length.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `start`  in  1  job request; sampled only in IDLE.
- `len`  in  LEN_W  beats in the job; sampled with `start`.
- `busy`  out  1  high from start acceptance to the end of the job.
- `done`  out  1  one-cycle pulse at job end.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  operand beat accepted when high together with `in_valid`.
- `in_data`  in  256  16×fp16 operands. Order from LSB: top_a1, top_b1, bot_a1, bot_b1, then the same four for DSPs 2, 3 and 4.
- `dsp_ops`  out  256  registered operands to the cascade, same packing as `in_data`.
- `dsp_result`  in  32  fp32 result from the last cascade stage.
- `out_valid`  out  1  FIFO head valid (first-word fall-through).
- `out_ready`  in  1  consumer accepts the head.
- `out_data`  out  32  fp32 result at the FIFO head.
- `out_last`  out  1  head is the final result of the job.

## Operation
- **FSM states:** IDLE, RUN, DRAIN.
- **IDLE:**
  - `start` with `len != 0`: load the beat counter with `len`, set `busy`, go to RUN.
  - `start` with `len == 0`: pulse `done` the next cycle, stay IDLE, `busy` stays 0.
- **RUN:**
  - `in_ready = (inflight + fifo_count < DEPTH)`.
  - Fire = `in_valid & in_ready`. On fire: `dsp_ops <= in_data`, decrement the beat counter, push a tag {valid=1, last=(counter==1)} into the tag pipe.
  - No fire: `dsp_ops <= 0` and push a tag {0, 0}.
  - Last beat fired: go to DRAIN.
- **DRAIN:** `in_ready = 0`. Stay until the handshake of the FIFO entry with `last = 1`. In that cycle pulse `done`, clear `busy`, go to IDLE.
- **Tag pipe:** LAT+1 entries. When the tag at its output is valid, write {`dsp_result`, last} into the FIFO that cycle.
- **inflight:** the number of valid tags in the pipe.
- **Credit rule:** `inflight + fifo_count < DEPTH` at fire time. This guarantees no FIFO overflow. A same-cycle pop does not add a credit.
- **FIFO behaviour:**
  - In-order, first-word fall-through.
  - A simultaneous push and pop is legal and leaves the count unchanged.
  - Read and write pointers wrap modulo DEPTH.
  - A push is never dropped.
- **Ignored inputs:** `start` is ignored while `busy` is high. `in_valid` is ignored outside RUN.
- **Reset (`reset = 0`):**
  - Immediately clears the FSM (to IDLE), counters, tags and FIFO pointers.
  - All outputs go to 0: `busy`, `done`, `in_ready`, `dsp_ops`, `out_valid`, `out_data`, `out_last`.
  - A job in progress is discarded, with no `done` pulse.

## Timing
- **Start to first ready:** `start` accepted at cycle s; RUN from s+1; `in_ready` can be high at s+1.
- **Beat latency:**
  - Fire at cycle t → `dsp_ops` valid at t+1.
  - The matching `dsp_result` is sampled in cycle t+1+LAT.
  - `out_valid` rises at t+2+LAT (LAT+2 = 6 cycles by default).
- **Throughput:** 1 beat/cycle while `out_ready = 1` (steady-state usage is LAT+2 < DEPTH).
- **`done`:** asserted in the cycle of the `out_last` handshake; `busy` is low the next cycle. A new `start` is accepted the cycle after `done`.
- **`out_data` / `out_last`:** valid only while `out_valid` is high; held stable until the handshake.

## Test plan
Bench model: `dsp_result` equals the sum of the 16-bit lanes of `dsp_ops`, delayed LAT cycles. Defaults LAT=4, DEPTH=8.

- **Single beat:** `len=1`, one fire at cycle t, `out_ready=1` → `out_valid` and `out_last` at t+6; `out_data` equals the model value; `done` pulse at t+6; `busy` low at t+7.
- **Streaming:** `len=20`, `in_valid` and `out_ready` always 1 → 20 consecutive fires; `in_ready` never drops; 20 in-order results on consecutive cycles; `out_last` only on the 20th.
- **Backpressure:** `len=20`, `out_ready=0` → exactly 8 beats accepted, then `in_ready=0`, FIFO full with no loss. Release `out_ready` → remaining 12 beats flow; all 20 results in order; `done` on the 20th pop.
- **Zero-length and start while busy:** `len=0` → `done` one cycle later, no `in_ready`, no output. A `start` pulse during a `len=5` job → ignored; exactly 5 results.
- **Reset mid-job:** `len=10`, `reset=0` after 5 fires → all outputs 0 immediately. After release, a new `len=3` job yields exactly 3 results and one `done`, with no stale data.

Source files
------------

// File: rtl/dsp_chain_sop_sequencer_if.sv
// Operand, cascade and result buses of the
// fp16 sum-of-products job sequencer.
interface dsp_chain_sop_sequencer_if;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic [255:0] dsp_ops;
  logic [31:0]  dsp_result;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;

  modport master (
    output in_valid, in_data,
    output dsp_result, out_ready,
    input  in_ready, dsp_ops,
    input  out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data,
    input  dsp_result, out_ready,
    output in_ready, dsp_ops,
    output out_valid, out_data, out_last
  );
endinterface

// File: rtl/dsp_chain_sop_sequencer.sv
// Streams operand beats into a non-stallable
// DSP cascade and buffers its results by credit.
module dsp_chain_sop_sequencer #(
  parameter int LAT   = 4,
  parameter int DEPTH = 8,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  dsp_chain_sop_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + LAT + 2);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic v;
    logic last;
  } tag_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } ent_t;

  state_t           state;
  state_t           state_nx;
  logic [LEN_W-1:0] cnt;
  tag_t             tag [LAT+1];
  ent_t             mem [DEPTH];
  ent_t             head;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    fcnt;
  logic [CW-1:0]    inflight;
  logic             zdone;
  logic             fire;
  logic             push;
  logic             pop;
  logic             last_beat;

  assign head      = mem[rptr];
  assign push      = tag[LAT].v;
  assign pop       = bus.out_valid & bus.out_ready;
  assign last_beat = (cnt == LEN_W'(1));
  assign busy      = (state != IDLE);

  assign bus.out_valid = (fcnt != '0);
  assign bus.out_data  = bus.out_valid ? head.data : '0;
  assign bus.out_last  = bus.out_valid & head.last;

  // Count beats still travelling through the cascade
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= LAT; i++)
      inflight = inflight + CW'(tag[i].v);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state, credit-gated ready and done pulse
  always_comb begin
    state_nx     = state;
    bus.in_ready = 1'b0;
    fire         = 1'b0;
    done         = zdone;
    unique case (state)
      IDLE: begin
        if (start && len != '0)
          state_nx = RUN;
      end
      RUN: begin
        bus.in_ready =
          (inflight + fcnt) < CW'(DEPTH);
        fire = bus.in_valid & bus.in_ready;
        if (fire && last_beat)
          state_nx = DRAIN;
      end
      DRAIN: begin
        if (pop && bus.out_last) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Beat counter, operand register and tag pipe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      zdone       <= 1'b0;
      bus.dsp_ops <= '0;
      for (int i = 0; i <= LAT; i++)
        tag[i] <= '0;
    end else begin
      zdone <= (state == IDLE) & start
             & (len == '0);
      if (state == IDLE && start)
        cnt <= len;
      else if (fire)
        cnt <= cnt - 1'b1;
      bus.dsp_ops <= fire ? bus.in_data : '0;
      tag[0] <= '{v: fire,
                  last: fire & last_beat};
      for (int i = 1; i <= LAT; i++)
        tag[i] <= tag[i-1];
    end
  end

  // Result FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      fcnt <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)
        fcnt <= fcnt + 1'b1;
      else if (!push && pop)
        fcnt <= fcnt - 1'b1;
    end
  end

  // Result FIFO storage
  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= '{data: bus.dsp_result,
                     last: tag[LAT].last};
  end
endmodule

// File: tb/tb_dsp_chain_sop_sequencer.sv
// Scoreboard bench for the sum-of-products
// job sequencer with a lane-sum cascade stub.
module tb_dsp_chain_sop_sequencer;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic        busy;
  logic        done;

  dsp_chain_sop_sequencer_if bus();

  dsp_chain_sop_sequencer #(
    .LAT(LAT), .DEPTH(8), .LEN_W(16)
  ) dut (
    .clk(clk), .reset(reset),
    .start(start), .len(len),
    .busy(busy), .done(done),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] casc [LAT];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int pop_at [2048];
  int fire_cyc = 0;
  bit rnd_ready = 1'b0;
  bit ready_lvl = 1'b1;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] lanesum(
    input logic [255:0] d);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 16; i++)
      s = s + 32'(d[i*16 +: 16]);
    return s;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++)
      r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string nm,
                       input longint act,
                       input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, req);
    end
  endtask

  // Cascade stub: lane sum of dsp_ops, LAT cycles late
  always @(posedge clk) begin
    casc[0] <= lanesum(bus.dsp_ops);
    for (int i = 1; i < LAT; i++)
      casc[i] <= casc[i-1];
  end
  assign bus.dsp_result = casc[LAT-1];

  // Consumer ready, fixed level or random
  always @(posedge clk) begin
    #1;
    bus.out_ready = rnd_ready ?
      1'($urandom_range(0, 1)) : ready_lvl;
  end

  // Monitor: pop the scoreboard on every handshake
  always @(negedge clk) begin
    if (reset) begin
      if (done) done_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        pop_at[pop_cnt % 2048] = cyc;
        pop_cnt++;
        check("sb_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sb_data", bus.out_data, e.d);
          check("sb_last", bus.out_last, e.l);
        end
      end
    end
  end

  task automatic do_start(input int l);
    @(posedge clk); #1;
    start = 1'b1;
    len   = 16'(l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n,
                      input int base,
                      input int jlen,
                      input bit rnd,
                      output int stalls);
    int fired;
    int k;
    fired  = 0;
    k      = 0;
    stalls = 0;
    while (fired < n && k < 500) begin
      @(posedge clk); #1;
      bus.in_valid = rnd ?
        1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data = rand256();
      @(negedge clk);
      if (bus.in_valid) begin
        if (bus.in_ready) begin
          exp_q.push_back('{lanesum(bus.in_data),
            1'(base + fired == jlen - 1)});
          fire_cyc = cyc;
          fired++;
        end else begin
          stalls++;
        end
      end
      k++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("feed_cnt", fired, n);
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (done_cnt < target && k < 300) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("done_cnt", done_cnt, target);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dexp;
    int p0;
    int st;
    int k;
    int gmax;
    int blocked;
    dexp = 0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", bus.in_ready, 0);
    check("rst_ops", |bus.dsp_ops, 0);
    check("rst_oval", bus.out_valid, 0);
    check("rst_odata", bus.out_data, 0);
    check("rst_olast", bus.out_last, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Single beat and its exact latency
    do_start(1);
    @(negedge clk);
    check("sb_busy", busy, 1);
    check("sb_first_ready", bus.in_ready, 1);
    feed(1, 0, 1, 1'b0, st);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.out_valid && k < 20);
    check("sb_lat", cyc - fire_cyc, LAT + 2);
    check("sb_olast", bus.out_last, 1);
    check("sb_done", done, 1);
    @(negedge clk);
    check("sb_busy_low", busy, 0);
    dexp++;
    wait_done(dexp);

    // Streaming at full rate
    p0 = pop_cnt;
    do_start(20);
    feed(20, 0, 20, 1'b0, st);
    check("st_stalls", st, 0);
    dexp++;
    wait_done(dexp);
    check("st_pops", pop_cnt - p0, 20);
    gmax = 0;
    for (int i = p0 + 1; i < p0 + 20; i++)
      if (pop_at[i % 2048] - pop_at[(i-1) % 2048]
          > gmax)
        gmax = pop_at[i % 2048]
             - pop_at[(i-1) % 2048];
    check("st_gap", gmax, 1);

    // Backpressure: credits stop at DEPTH
    ready_lvl = 1'b0;
    p0 = pop_cnt;
    do_start(20);
    feed(8, 0, 20, 1'b0, st);
    blocked = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = rand256();
      @(negedge clk);
      if (bus.in_ready) blocked++;
    end
    check("bp_ready_low", blocked, 0);
    check("bp_full", bus.out_valid, 1);
    check("bp_no_pop", pop_cnt - p0, 0);
    ready_lvl = 1'b1;
    feed(12, 8, 20, 1'b0, st);
    dexp++;
    wait_done(dexp);
    check("bp_pops", pop_cnt - p0, 20);

    // Zero-length job
    p0 = pop_cnt;
    do_start(0);
    @(negedge clk);
    check("zl_done", done, 1);
    check("zl_busy", busy, 0);
    check("zl_ready", bus.in_ready, 0);
    @(negedge clk);
    check("zl_pulse", done, 0);
    dexp++;
    repeat (10) @(negedge clk);
    check("zl_pops", pop_cnt - p0, 0);
    check("zl_done_cnt", done_cnt, dexp);

    // Start while busy is ignored
    p0 = pop_cnt;
    do_start(5);
    @(posedge clk); #1;
    start = 1'b1;
    len   = 16'd9;
    @(posedge clk); #1;
    start = 1'b0;
    feed(5, 0, 5, 1'b0, st);
    dexp++;
    wait_done(dexp);
    repeat (10) @(negedge clk);
    check("sw_pops", pop_cnt - p0, 5);
    check("sw_busy", busy, 0);
    check("sw_done_cnt", done_cnt, dexp);

    // Random valid and ready
    rnd_ready = 1'b1;
    p0 = pop_cnt;
    do_start(15);
    feed(15, 0, 15, 1'b1, st);
    dexp++;
    wait_done(dexp);
    rnd_ready = 1'b0;
    check("rn_pops", pop_cnt - p0, 15);

    // Reset in the middle of a job
    do_start(10);
    feed(5, 0, 10, 1'b0, st);
    #2;
    reset = 1'b0;
    #1;
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    check("mr_ready", bus.in_ready, 0);
    check("mr_ops", |bus.dsp_ops, 0);
    check("mr_oval", bus.out_valid, 0);
    check("mr_odata", bus.out_data, 0);
    check("mr_olast", bus.out_last, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    check("mr_no_done", done_cnt, dexp);
    p0 = pop_cnt;
    do_start(3);
    feed(3, 0, 3, 1'b0, st);
    dexp++;
    wait_done(dexp);
    repeat (10) @(negedge clk);
    check("mr_pops", pop_cnt - p0, 3);
    check("mr_done_cnt", done_cnt, dexp);
    check("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
